// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SIZE = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    // States in which the loader consumes bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Packs a byte stream into 32-bit big-endian words (first byte lands in [31:24]).
// word_valid_o is a combinational pulse on the accept of the 4th byte, with
// word_o presenting the completed word in that same cycle.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

    // Shift in accepted bytes and track position within the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed, checksummed program image into instruction memory
// and keeps the core held until the image is complete and verified.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte, then size check
// DATA   | packing payload bytes and writing words
// CHECK  | waiting for the XOR checksum byte
// DONE   | image good, core released
// ERROR  | oversize length or bad checksum, core held
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                MEM_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int IDX_W = $clog2(MEM_WORDS) + 1;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic        accept;
    logic        restart;
    logic [15:0] len_full;
    logic [31:0] pk_word;
    logic        pk_word_valid;

    assign accept   = in_valid_i && in_ready_q;
    assign restart  = start_i && !accepts_bytes(state_q);
    assign len_full = {len_q[15:8], in_data_i};

    byte_to_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (restart),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (in_data_i),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    state_d    = LEN_HI;
                    len_d      = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data_i, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (32'(len_full) > MEM_WORDS) begin
                        state_d    = ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_SIZE;
                        cpu_hold_d = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data_i;
                    if (pk_word_valid) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = pk_word;
                        im_addr_d  = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
                        word_idx_d = word_idx_q + IDX_W'(1);
                        if (16'(word_idx_q) == len_q - 16'd1) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (in_data_i == csum_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = accepts_bytes(state_d);
    end

    // State, datapath and output registers; reset drops everything back to idle with the core held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign im_we_o    = im_we_q;
    assign im_addr_o  = im_addr_q;
    assign im_wdata_o = im_wdata_q;
    assign cpu_hold_o = cpu_hold_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_imem_program_loader;

    localparam int          MEMW = 256;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_ready_o;
    logic        im_we_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_wdata_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int          tests = 0;
    int          fails = 0;
    int          acc_cnt = 0;
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [31:0] frame_w[$];

    imem_program_loader #(
        .ADDR_W    (32),
        .MEM_WORDS (MEMW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .im_we_o    (im_we_o),
        .im_addr_o  (im_addr_o),
        .im_wdata_o (im_wdata_o),
        .cpu_hold_o (cpu_hold_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    // Capture memory writes away from the active edge.
    always @(negedge clk) begin
        if (im_we_o === 1'b1) begin
            cap_addr.push_back(im_addr_o);
            cap_data.push_back(im_wdata_o);
        end
    end

    // Count handshakes completed on each rising edge.
    always @(posedge clk) begin
        if (in_valid_i === 1'b1 && in_ready_o === 1'b1) acc_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Offer one byte until it is taken; optional random valid toggling and idle gaps.
    task automatic send_byte(input logic [7:0] b, input bit gappy);
        bit got = 1'b0;
        int guard = 0;
        while (!got && guard < 200) begin
            in_valid_i = gappy ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data_i  = in_valid_i ? b : 8'($urandom);
            if (in_valid_i && in_ready_o) got = 1'b1;
            @(negedge clk);
            guard++;
        end
        chk("byte_accepted", 64'(got), 64'd1);
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
        if (gappy) repeat ($urandom_range(2, 5)) @(negedge clk);
    endtask

    // csum_mode: -1 correct checksum, -2 corrupted checksum, 0..255 literal byte.
    task automatic run_frame(input string tag, input int n, input int csum_mode,
                             input bit gappy, input bit do_start);
        logic [7:0] cs;
        logic [7:0] csb;
        cap_addr.delete();
        cap_data.delete();
        acc_cnt = 0;
        cs = 8'h00;
        foreach (frame_w[i]) cs ^= frame_w[i][31:24] ^ frame_w[i][23:16] ^ frame_w[i][15:8] ^ frame_w[i][7:0];
        if (csum_mode == -1)      csb = cs;
        else if (csum_mode == -2) csb = cs ^ 8'($urandom_range(1, 255));
        else                      csb = 8'(csum_mode);

        if (do_start) start_pulse();
        send_byte(8'(n >> 8), gappy);
        send_byte(8'(n), gappy);

        if (n > MEMW) begin
            chk({tag, "_ready"}, 64'(in_ready_o), 64'd0);
            chk({tag, "_err"}, 64'(err_o), 64'd1);
            chk({tag, "_code"}, 64'(err_code_o), 64'd1);
            chk({tag, "_hold"}, 64'(cpu_hold_o), 64'd1);
            chk({tag, "_done"}, 64'(done_o), 64'd0);
            repeat (2) @(negedge clk);
            chk({tag, "_nwrites"}, 64'(cap_addr.size()), 64'd0);
            chk({tag, "_accepted"}, 64'(acc_cnt), 64'd2);
            return;
        end

        for (int i = 0; i < n; i++)
            for (int k = 3; k >= 0; k--)
                send_byte(frame_w[i][8*k +: 8], gappy);
        send_byte(csb, gappy);
        repeat (2) @(negedge clk);

        chk({tag, "_nwrites"}, 64'(cap_addr.size()), 64'(n));
        for (int i = 0; i < n && i < cap_addr.size(); i++) begin
            chk({tag, "_addr"}, 64'(cap_addr[i]), 64'(BASE + 32'(4 * i)));
            chk({tag, "_data"}, 64'(cap_data[i]), 64'(frame_w[i]));
        end
        if (csb == cs) begin
            chk({tag, "_done"}, 64'(done_o), 64'd1);
            chk({tag, "_err"}, 64'(err_o), 64'd0);
            chk({tag, "_code"}, 64'(err_code_o), 64'd0);
            chk({tag, "_hold"}, 64'(cpu_hold_o), 64'd0);
        end else begin
            chk({tag, "_done"}, 64'(done_o), 64'd0);
            chk({tag, "_err"}, 64'(err_o), 64'd1);
            chk({tag, "_code"}, 64'(err_code_o), 64'd2);
            chk({tag, "_hold"}, 64'(cpu_hold_o), 64'd1);
        end
        chk({tag, "_ready"}, 64'(in_ready_o), 64'd0);
        chk({tag, "_accepted"}, 64'(acc_cnt), 64'(4 * n + 3));
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_we", 64'(im_we_o), 64'd0);
        chk("rst_addr", 64'(im_addr_o), 64'(BASE));
        chk("rst_wdata", 64'(im_wdata_o), 64'd0);
        chk("rst_hold", 64'(cpu_hold_o), 64'd1);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_code", 64'(err_code_o), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", 64'(in_ready_o), 64'd0);
        chk("idle_hold", 64'(cpu_hold_o), 64'd1);

        // Two-word image; its payload XORs to 0x00.
        frame_w = '{32'h12345678, 32'h9ABCDEF0};
        run_frame("two_word", 2, 8'h00, 1'b0, 1'b1);

        // Zero-length image, then restart from DONE.
        frame_w = '{};
        run_frame("zero_len", 0, 8'h00, 1'b0, 1'b1);
        start_pulse();
        chk("restart_hold", 64'(cpu_hold_o), 64'd1);
        chk("restart_done", 64'(done_o), 64'd0);
        chk("restart_ready", 64'(in_ready_o), 64'd1);

        // Continue the restarted load: AA^BB^CC^DD is 0x00, so a 0x00 byte matches.
        frame_w = '{32'hAABBCCDD};
        run_frame("csum_lit", 1, 8'h00, 1'b0, 1'b0);
        run_frame("csum_bad", 1, 8'h5A, 1'b0, 1'b1);

        // Length just over capacity.
        frame_w = '{};
        run_frame("oversize", 257, -1, 1'b0, 1'b1);

        // Same two-word image with random stalls.
        frame_w = '{32'h12345678, 32'h9ABCDEF0};
        run_frame("gappy", 2, -1, 1'b1, 1'b1);

        // Reset after six payload bytes.
        cap_addr.delete();
        cap_data.delete();
        start_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(8'h12 + 8'(k) * 8'h22, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_we", 64'(im_we_o), 64'd0);
        chk("midrst_hold", 64'(cpu_hold_o), 64'd1);
        chk("midrst_ready", 64'(in_ready_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_nwrites", 64'(cap_addr.size()), 64'd1);
        if (cap_data.size() > 0) chk("midrst_data0", 64'(cap_data[0]), 64'h12345678);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_rst", 2, -1, 1'b0, 1'b1);

        // Largest allowed image.
        frame_w = '{};
        for (int i = 0; i < MEMW; i++) frame_w.push_back($urandom);
        run_frame("full_mem", MEMW, -1, 1'b0, 1'b1);

        // Random images.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            frame_w = '{};
            for (int i = 0; i < n; i++) frame_w.push_back($urandom);
            run_frame("rand", n, ($urandom_range(0, 2) == 0) ? -2 : -1,
                      ($urandom_range(0, 1) == 1), 1'b1);
        end

        frame_w = '{};
        run_frame("rand_oversize", $urandom_range(MEMW + 1, 65535), -1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
